// File: rtl/stopwatch_pkg.sv
// Shared encodings and sizing for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StLap   = 2'd3
    } sw_state_e;

    localparam int unsigned LapHoldTicksDefault = 300;

    // Smallest width whose range covers 0..ticks inclusive.
    function automatic int unsigned hold_width(input int unsigned ticks);
        return $clog2(ticks + 1);
    endfunction

    localparam int unsigned HoldWDefault = hold_width(LapHoldTicksDefault);

endpackage

// File: rtl/stopwatch_controller_if.sv
// Button, timebase and control signals between the stopwatch controller and its environment.
interface stopwatch_controller_if;
    logic       btn_start_stop;
    logic       btn_lap;
    logic       btn_clear;
    logic       tick;
    logic       count_max;
    logic       div_en;
    logic       div_clr;
    logic       cnt_en;
    logic       cnt_clr;
    logic       disp_freeze;
    logic [1:0] state;

    modport master (
        output btn_start_stop, btn_lap, btn_clear, tick, count_max,
        input  div_en, div_clr, cnt_en, cnt_clr, disp_freeze, state
    );

    modport slave (
        input  btn_start_stop, btn_lap, btn_clear, tick, count_max,
        output div_en, div_clr, cnt_en, cnt_clr, disp_freeze, state
    );
endinterface

// File: rtl/stopwatch_controller_button_sync.sv
// Synchronizes one asynchronous button and emits a single-cycle pulse on its rising edge.
module button_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic res,
    input  logic i_btn,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;

    always_ff @(posedge clk_in) begin
        if (res) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch run/pause/lap/clear sequencer driving the divider, time counter and display latch.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned LAP_HOLD_TICKS = LapHoldTicksDefault,
    parameter int unsigned HOLD_W         = HoldWDefault
) (
    input logic                  clk_in,
    input logic                  res,
    stopwatch_controller_if.slave bus
);

    logic w_ss;
    logic w_lap;
    logic w_clr;

    button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_in  (clk_in),
        .res     (res),
        .i_btn   (bus.btn_start_stop),
        .o_pulse (w_ss)
    );

    button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lap (
        .clk_in  (clk_in),
        .res     (res),
        .i_btn   (bus.btn_lap),
        .o_pulse (w_lap)
    );

    button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
        .clk_in  (clk_in),
        .res     (res),
        .i_btn   (bus.btn_clear),
        .o_pulse (w_clr)
    );

    sw_state_e         r_state;
    logic [HOLD_W-1:0] r_hold;
    logic              r_div_en;
    logic              r_div_clr;
    logic              r_cnt_en;
    logic              r_cnt_clr;
    logic              r_freeze;

    sw_state_e         w_state_d;
    logic [HOLD_W-1:0] w_hold_d;
    logic              w_div_clr_d;
    logic              w_cnt_clr_d;
    logic              w_counting;

    assign w_counting = (r_state == StRun) || (r_state == StLap);

    always_comb begin
        w_state_d   = r_state;
        w_hold_d    = r_hold;
        w_div_clr_d = 1'b0;
        w_cnt_clr_d = 1'b0;
        if (w_clr) begin
            w_state_d   = StIdle;
            w_hold_d    = '0;
            w_div_clr_d = 1'b1;
            w_cnt_clr_d = 1'b1;
        end else if (w_ss) begin
            w_hold_d = '0;
            unique case (r_state)
                StIdle: begin
                    w_state_d   = StRun;
                    w_div_clr_d = 1'b1;
                end
                StPause:      w_state_d = StRun;
                StRun, StLap: w_state_d = StPause;
            endcase
        end else if (w_lap && w_counting) begin
            w_state_d = StLap;
            w_hold_d  = HOLD_W'(LAP_HOLD_TICKS);
        end else if (w_counting && bus.tick && bus.count_max) begin
            w_state_d = StPause;
            w_hold_d  = '0;
        end else if ((r_state == StLap) && bus.tick) begin
            w_hold_d = r_hold - HOLD_W'(1);
            if (r_hold == HOLD_W'(1)) begin
                w_state_d = StRun;
            end
        end
    end

    // Outputs follow the next state; cnt_en is gated by the pre-transition state.
    always_ff @(posedge clk_in) begin
        if (res) begin
            r_state   <= StIdle;
            r_hold    <= '0;
            r_div_en  <= 1'b0;
            r_div_clr <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_freeze  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_hold    <= w_hold_d;
            r_div_en  <= (w_state_d == StRun) || (w_state_d == StLap);
            r_div_clr <= w_div_clr_d;
            r_cnt_en  <= bus.tick && w_counting && !bus.count_max;
            r_cnt_clr <= w_cnt_clr_d;
            r_freeze  <= (w_state_d == StLap);
        end
    end

    assign bus.state       = r_state;
    assign bus.div_en      = r_div_en;
    assign bus.div_clr     = r_div_clr;
    assign bus.cnt_en      = r_cnt_en;
    assign bus.cnt_clr     = r_cnt_clr;
    assign bus.disp_freeze = r_freeze;

endmodule
